axi_ace_param_mem: RTL and testbench
====================================

AXI_ACE_PARAM_MEM -- requirements
Module: axi_ace_param_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits (8..256, multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 6, word-index width; depth = 2**ADDR_W words.
REQ-003 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports arvalid in 1, arready out 1, araddr in ADDR_W: read address channel.
REQ-006 SHALL have ports rvalid out 1, rready in 1, rdata out DATA_W, rresp out 2: read data channel.
REQ-007 SHALL have ports awvalid in 1, awready out 1, awaddr in ADDR_W: write address channel.
REQ-008 SHALL have ports wvalid in 1, wready out 1, wdata in DATA_W: write data channel.
REQ-009 SHALL have ports bvalid out 1, bready in 1, bresp out 2: write response channel.
REQ-010 SHALL have ports acvalid in 1, acready out 1, acaddr in ADDR_W: snoop address channel.
REQ-011 SHALL have ports crvalid out 1, crready in 1, crresp out 2: snoop response; crresp[0] = line was valid, crresp[1] = line was dirty.

Function
REQ-012 SHALL hold a DATA_W x 2**ADDR_W memory plus a 2-bit line state per word: INVALID, UNIQUE_CLEAN, UNIQUE_DIRTY.
REQ-013 SHALL implement FSM states IDLE, RD_RESP, WR_DATA, WR_RESP, SNP_RESP; one transaction in flight at a time.
REQ-014 In IDLE, SHALL grant exactly one request per cycle with priority acvalid > awvalid > arvalid; only the granted ready (acready/awready/arready) is high that cycle, combinationally from state and valids.
REQ-015 All of acready/awready/arready SHALL be 0 outside IDLE.
REQ-016 Read: AR handshake in cycle N SHALL register rdata = mem[araddr] and go to RD_RESP; rvalid high from N+1, rdata/rresp stable until rready; back to IDLE on the R handshake.
REQ-017 Read SHALL promote an INVALID line to UNIQUE_CLEAN and leave CLEAN/DIRTY unchanged; rresp = 2'b00 always.
REQ-018 Write: AW handshake SHALL latch awaddr and go to WR_DATA; wready high only in WR_DATA.
REQ-019 On the W handshake SHALL write mem[addr] = wdata, set the line to UNIQUE_DIRTY, and go to WR_RESP.
REQ-020 In WR_RESP, bvalid SHALL be high with bresp = 2'b00 until bready, then return to IDLE.
REQ-021 Snoop: AC handshake SHALL sample the line state into crresp, set the line INVALID in the same edge, and go to SNP_RESP.
REQ-022 In SNP_RESP, crvalid SHALL be high and crresp stable until crready, then return to IDLE.
REQ-023 The earliest next grant after any response handshake SHALL be the following cycle (IDLE for one cycle minimum).
REQ-024 Memory contents SHALL be unaffected by snoops; a snoop only changes line state.

Reset
REQ-025 rst_n low SHALL force state IDLE; arready/awready/acready/rvalid/wready/bvalid/crvalid = 0; rdata = 0; rresp/bresp/crresp = 0.
REQ-026 Reset SHALL set every line state to INVALID; memory data is not reset.
REQ-027 Reset mid-transaction SHALL abandon it: a pending write with no W handshake leaves the memory unmodified.

Configuration
REQ-028 With AXI_ACE_MEM_SNOOP_DATA_EN defined, SHALL add port crdata out DATA_W = mem[acaddr] captured at the AC handshake, held with crresp, reset 0.
REQ-029 Without AXI_ACE_MEM_SNOOP_DATA_EN, the crdata port and its register SHALL not exist; all other behaviour is identical.

Structure
REQ-030 Package axi_ace_mem_pkg SHALL hold the line-state enum, the FSM-state enum, and the RESP_OKAY = 2'b00 constant.
REQ-031 The line-state array with its read/promote/set-dirty/invalidate ports SHALL be the sub-module ace_line_state_tbl.

Verification
REQ-032 Reset, write 0xDEADBEEF to addr 5 (AW then W), read addr 5 -> bvalid once with bresp 0; rdata = 0xDEADBEEF one cycle after the AR handshake.
REQ-033 Write to addr 3, snoop addr 3, snoop addr 3 again -> first crresp = 2'b11, second crresp = 2'b00; a following read of addr 3 still returns the written data.
REQ-034 Read addr 9 after reset, then snoop addr 9 -> crresp = 2'b01.
REQ-035 acvalid, awvalid and arvalid all high in the same IDLE cycle -> acready only; the write and then the read are served in later IDLE windows, in that order.
REQ-036 Hold rready/bready/crready low for 4 cycles -> the respective valid and payload stay stable and no new ready is asserted.
REQ-037 Assert rst_n low while in WR_DATA, then read the target address -> the old data is returned; with AXI_ACE_MEM_SNOOP_DATA_EN, crdata on a later snoop equals that old data.

Source files
------------

// File: rtl/axi_ace_mem_pkg.sv
// Shared types for the ACE-lite parameter memory: cache-line state encoding,
// controller FSM states and the fixed OKAY response code.
// Line-state encoding is chosen so it maps bit-for-bit onto crresp {dirty, valid}.
package axi_ace_mem_pkg;

  // bit0 = line valid, bit1 = line dirty
  typedef enum logic [1:0] {
    INVALID      = 2'b00,
    UNIQUE_CLEAN = 2'b01,
    UNIQUE_DIRTY = 2'b11
  } line_state_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_RESP  = 3'd1,
    WR_DATA  = 3'd2,
    WR_RESP  = 3'd3,
    SNP_RESP = 3'd4
  } fsm_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ace_line_state_tbl.sv
// Per-word coherence state table (INVALID / UNIQUE_CLEAN / UNIQUE_DIRTY).
// Latency: rd_state is combinational from rd_addr; updates take effect next edge.
// Backpressure: none; the controller issues at most one update per cycle.
// Ports: clk/rst_n (sync, active-low, clears all lines to INVALID);
//   rd_addr -> rd_state; promote_en/addr (INVALID -> UNIQUE_CLEAN only);
//   dirty_en/addr (-> UNIQUE_DIRTY); inv_en/addr (-> INVALID).
module ace_line_state_tbl
  import axi_ace_mem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output line_state_e       rd_state,
  input  logic              promote_en,
  input  logic [ADDR_W-1:0] promote_addr,
  input  logic              dirty_en,
  input  logic [ADDR_W-1:0] dirty_addr,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  line_state_e state_q [DEPTH];
  line_state_e state_d [DEPTH];

  always_comb begin
    state_d = state_q;
    // A read only upgrades an untracked line; clean/dirty lines keep their state.
    if (promote_en && (state_q[promote_addr] == INVALID)) begin
      state_d[promote_addr] = UNIQUE_CLEAN;
    end
    if (dirty_en) begin
      state_d[dirty_addr] = UNIQUE_DIRTY;
    end
    if (inv_en) begin
      state_d[inv_addr] = INVALID;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '{default: INVALID};
    end else begin
      state_q <= state_d;
    end
  end

  assign rd_state = state_q[rd_addr];

endmodule

// File: rtl/axi_ace_param_mem.sv
// Single-outstanding AXI/ACE-style word memory with per-line coherence state.
// Latency: read data registered at AR handshake, rvalid the next cycle; one transaction in flight.
// Backpressure: responses hold valid+payload until ready; no request is granted outside IDLE.
// Ports: clk, rst_n (sync, active-low); AR/R, AW/W/B, AC/CR channels (DATA_W data, ADDR_W word index).
// Optional: define AXI_ACE_MEM_SNOOP_DATA_EN to add crdata (mem[acaddr] captured at the AC handshake).
module axi_ace_param_mem
  import axi_ace_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              acvalid,
  output logic              acready,
  input  logic [ADDR_W-1:0] acaddr,
  output logic              crvalid,
  input  logic              crready,
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
  output logic [DATA_W-1:0] crdata,
`endif
  output logic [1:0]        crresp
);

  localparam int DEPTH = 2 ** ADDR_W;

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        crresp_q, crresp_d;
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
  logic [DATA_W-1:0] crdata_q, crdata_d;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;

  line_state_e ls_rd_state;
  logic        ls_promote, ls_dirty, ls_inv;

  ace_line_state_tbl #(.ADDR_W(ADDR_W)) u_line_state (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr      (acaddr),
    .rd_state     (ls_rd_state),
    .promote_en   (ls_promote),
    .promote_addr (araddr),
    .dirty_en     (ls_dirty),
    .dirty_addr   (waddr_q),
    .inv_en       (ls_inv),
    .inv_addr     (acaddr)
  );

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    rdata_d    = rdata_q;
    crresp_d   = crresp_q;
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
    crdata_d   = crdata_q;
`endif
    arready    = 1'b0;
    awready    = 1'b0;
    acready    = 1'b0;
    rvalid     = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    crvalid    = 1'b0;
    mem_we     = 1'b0;
    ls_promote = 1'b0;
    ls_dirty   = 1'b0;
    ls_inv     = 1'b0;
    // Everything is gated while reset is asserted so no handshake (in
    // particular a W beat of an abandoned write) can land in that cycle.
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          // Fixed priority: snoop > write > read, one grant per cycle.
          if (acvalid) begin
            acready  = 1'b1;
            crresp_d = ls_rd_state;
            ls_inv   = 1'b1;
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
            crdata_d = mem_q[acaddr];
`endif
            state_d  = SNP_RESP;
          end else if (awvalid) begin
            awready = 1'b1;
            waddr_d = awaddr;
            state_d = WR_DATA;
          end else if (arvalid) begin
            arready    = 1'b1;
            rdata_d    = mem_q[araddr];
            ls_promote = 1'b1;
            state_d    = RD_RESP;
          end
        end
        RD_RESP: begin
          rvalid = 1'b1;
          if (rready) state_d = IDLE;
        end
        WR_DATA: begin
          wready = 1'b1;
          if (wvalid) begin
            mem_we   = 1'b1;
            ls_dirty = 1'b1;
            state_d  = WR_RESP;
          end
        end
        WR_RESP: begin
          bvalid = 1'b1;
          if (bready) state_d = IDLE;
        end
        SNP_RESP: begin
          crvalid = 1'b1;
          if (crready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      waddr_q  <= '0;
      rdata_q  <= '0;
      crresp_q <= '0;
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
      crdata_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      rdata_q  <= rdata_d;
      crresp_q <= crresp_d;
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
      crdata_q <= crdata_d;
`endif
    end
  end

  // Storage array: contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[waddr_q] <= wdata;
    end
  end

  assign rdata  = rdata_q;
  assign rresp  = RESP_OKAY;
  assign bresp  = RESP_OKAY;
  assign crresp = crresp_q;
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
  assign crdata = crdata_q;
`endif

endmodule

// File: tb/tb_axi_ace_param_mem.sv
`timescale 1ns/1ps
module tb_axi_ace_param_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
  localparam bit SNP_DATA = 1'b1;
`else
  localparam bit SNP_DATA = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              arvalid = 0, arready, rvalid, rready = 0;
  logic [ADDR_W-1:0] araddr = '0, awaddr = '0, acaddr = '0;
  logic [DATA_W-1:0] rdata, wdata = '0, crd_mon;
  logic [1:0]        rresp, bresp, crresp;
  logic              awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic              acvalid = 0, acready, crvalid, crready = 0;
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
  logic [DATA_W-1:0] crdata;
  assign crd_mon = crdata;
`else
  assign crd_mon = '0;
`endif

  axi_ace_param_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .acvalid(acvalid), .acready(acready), .acaddr(acaddr),
    .crvalid(crvalid), .crready(crready),
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
    .crdata(crdata),
`endif
    .crresp(crresp)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entry: ch 0 = R, 1 = B, 2 = CR
  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
    bit                dchk;
    logic [1:0]        resp;
  } exp_t;
  exp_t sb_q[$];

  typedef enum int {OP_WR, OP_RD, OP_SNP} op_e;
  typedef struct {
    op_e               op;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                dchk;
    logic [1:0]        resp;
    int                stall;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return arready;
      1: return awready;
      2: return wready;
      3: return acready;
      4: return rvalid;
      5: return bvalid;
      6: return crvalid;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] payload(input int w);
    case (w)
      4: return {32'h0, rdata};
      5: return {62'h0, bresp};
      6: return {62'h0, crresp};
      default: return 64'h0;
    endcase
  endfunction

  // Called just after a negedge; returns at a negedge+1 where the signal is high.
  task automatic wait_for(input int w, input string nm);
    int n = 0;
    #1;
    while (!sel(w) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (!sel(w)) begin
      n_vec++; n_err++;
      $display("FAIL timeout_%s: still low after %0d cycles, expected high", nm, n);
    end
  endtask

  // Hold the response ready low while hammering all request valids.
  task automatic stall(input int w, input int n, input logic [63:0] pay, input bit pchk);
    for (int i = 0; i < n; i++) begin
      arvalid = 1; awvalid = 1; acvalid = 1;
      #1;
      chk("stall_valid", {63'h0, sel(w)}, 64'h1);
      if (pchk) chk("stall_payload", payload(w), pay);
      chk("stall_no_ready", {61'h0, arready, awready, acready}, 64'h0);
      @(negedge clk);
    end
    arvalid = 0; awvalid = 0; acvalid = 0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int st);
    sb_q.push_back('{ch: 1, data: '0, dchk: 1'b0, resp: 2'b00});
    @(negedge clk); awvalid = 1; awaddr = a; wait_for(1, "awready");
    @(negedge clk); awvalid = 0; wvalid = 1; wdata = d; wait_for(2, "wready");
    @(negedge clk); wvalid = 0;
    stall(5, st, 64'h0, 1'b1);
    bready = 1; wait_for(5, "bvalid");
    @(negedge clk); bready = 0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit dchk, input int st);
    sb_q.push_back('{ch: 0, data: d, dchk: dchk, resp: 2'b00});
    @(negedge clk); arvalid = 1; araddr = a; wait_for(0, "arready");
    @(negedge clk); arvalid = 0;
    stall(4, st, {32'h0, d}, dchk);
    rready = 1; wait_for(4, "rvalid");
    @(negedge clk); rready = 0;
  endtask

  task automatic do_snoop(input logic [ADDR_W-1:0] a, input logic [1:0] r, input logic [DATA_W-1:0] d, input bit dchk, input int st);
    sb_q.push_back('{ch: 2, data: d, dchk: dchk && SNP_DATA, resp: r});
    @(negedge clk); acvalid = 1; acaddr = a; wait_for(3, "acready");
    @(negedge clk); acvalid = 0;
    stall(6, st, {62'h0, r}, 1'b1);
    crready = 1; wait_for(6, "crvalid");
    @(negedge clk); crready = 0;
  endtask

  task automatic mon(input int ch, input logic [DATA_W-1:0] d, input logic [1:0] r);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_unexpected: response on channel %0d, expected none", ch);
    end else begin
      e = sb_q.pop_front();
      chk("sb_channel", 64'(ch), 64'(e.ch));
      chk("sb_resp", {62'h0, r}, {62'h0, e.resp});
      if (e.dchk) chk("sb_data", {32'h0, d}, {32'h0, e.data});
    end
  endtask

  // Response monitor: sampled mid-low-phase, before the handshake edge.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rvalid && rready)   mon(0, rdata, rresp);
      if (bvalid && bready)   mon(1, '0, bresp);
      if (crvalid && crready) mon(2, crd_mon, crresp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all request valids high: nothing may be granted.
    arvalid = 1; awvalid = 1; acvalid = 1; wvalid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_arready", {63'h0, arready}, 64'h0);
    chk("rst_awready", {63'h0, awready}, 64'h0);
    chk("rst_acready", {63'h0, acready}, 64'h0);
    chk("rst_wready",  {63'h0, wready},  64'h0);
    chk("rst_valids",  {61'h0, rvalid, bvalid, crvalid}, 64'h0);
    chk("rst_rdata",   {32'h0, rdata}, 64'h0);
    chk("rst_resps",   {58'h0, rresp, bresp, crresp}, 64'h0);
`ifdef AXI_ACE_MEM_SNOOP_DATA_EN
    chk("rst_crdata",  {32'h0, crdata}, 64'h0);
`endif
    arvalid = 0; awvalid = 0; acvalid = 0; wvalid = 0;
    rst_n = 1;

    vt.push_back('{OP_WR,  6'd5,  32'hDEADBEEF, 1, 2'b00, 0});
    vt.push_back('{OP_RD,  6'd5,  32'hDEADBEEF, 1, 2'b00, 4});
    vt.push_back('{OP_WR,  6'd3,  32'h12345678, 1, 2'b00, 4});
    vt.push_back('{OP_SNP, 6'd3,  32'h12345678, 1, 2'b11, 4});
    vt.push_back('{OP_SNP, 6'd3,  32'h12345678, 1, 2'b00, 0});
    vt.push_back('{OP_RD,  6'd3,  32'h12345678, 1, 2'b00, 0});
    vt.push_back('{OP_RD,  6'd9,  32'h0,        0, 2'b00, 0});
    vt.push_back('{OP_SNP, 6'd9,  32'h0,        0, 2'b01, 0});
    vt.push_back('{OP_RD,  6'd5,  32'hDEADBEEF, 1, 2'b00, 0});
    vt.push_back('{OP_SNP, 6'd5,  32'hDEADBEEF, 1, 2'b11, 0});
    vt.push_back('{OP_WR,  6'd63, 32'hCAFEF00D, 1, 2'b00, 0});
    vt.push_back('{OP_RD,  6'd63, 32'hCAFEF00D, 1, 2'b00, 0});
    vt.push_back('{OP_SNP, 6'd63, 32'hCAFEF00D, 1, 2'b11, 0});
    vt.push_back('{OP_RD,  6'd0,  32'h0,        0, 2'b00, 0});
    vt.push_back('{OP_SNP, 6'd0,  32'h0,        0, 2'b01, 0});
    vt.push_back('{OP_RD,  6'd63, 32'hCAFEF00D, 1, 2'b00, 0});
    vt.push_back('{OP_SNP, 6'd63, 32'hCAFEF00D, 1, 2'b01, 0});

    foreach (vt[i]) begin
      case (vt[i].op)
        OP_WR:   do_write(vt[i].a, vt[i].d, vt[i].stall);
        OP_RD:   do_read(vt[i].a, vt[i].d, vt[i].dchk, vt[i].stall);
        default: do_snoop(vt[i].a, vt[i].resp, vt[i].d, vt[i].dchk, vt[i].stall);
      endcase
    end

    // All three requests at once: snoop first, then write, then read.
    sb_q.push_back('{ch: 2, data: '0, dchk: 1'b0, resp: 2'b00});
    sb_q.push_back('{ch: 1, data: '0, dchk: 1'b0, resp: 2'b00});
    sb_q.push_back('{ch: 0, data: 32'h0BADF00D, dchk: 1'b1, resp: 2'b00});
    @(negedge clk);
    acvalid = 1; acaddr = 6'd20; awvalid = 1; awaddr = 6'd21; arvalid = 1; araddr = 6'd21;
    #1;
    chk("prio_acready", {63'h0, acready}, 64'h1);
    chk("prio_others_low", {62'h0, awready, arready}, 64'h0);
    @(negedge clk); acvalid = 0; crready = 1; #1;
    chk("prio_snp_crvalid", {63'h0, crvalid}, 64'h1);
    chk("prio_snp_no_ready", {62'h0, awready, arready}, 64'h0);
    @(negedge clk); crready = 0; #1;
    chk("prio_aw_next_cycle", {63'h0, awready}, 64'h1);
    chk("prio_ar_waits", {63'h0, arready}, 64'h0);
    @(negedge clk); awvalid = 0; wvalid = 1; wdata = 32'h0BADF00D; #1;
    chk("prio_wready", {63'h0, wready}, 64'h1);
    chk("prio_ar_waits_wr", {63'h0, arready}, 64'h0);
    @(negedge clk); wvalid = 0; bready = 1; #1;
    chk("prio_bvalid", {63'h0, bvalid}, 64'h1);
    @(negedge clk); bready = 0; #1;
    chk("prio_ar_grant", {63'h0, arready}, 64'h1);
    @(negedge clk); arvalid = 0; rready = 1; #1;
    chk("prio_rvalid", {63'h0, rvalid}, 64'h1);
    @(negedge clk); rready = 0;

    // Reset while waiting for write data: the write must be abandoned.
    do_write(6'd7, 32'h11111111, 0);
    @(negedge clk); awvalid = 1; awaddr = 6'd7; #1;
    chk("abort_awready", {63'h0, awready}, 64'h1);
    @(negedge clk); awvalid = 0; #1;
    chk("abort_in_wr_data", {63'h0, wready}, 64'h1);
    rst_n = 0; wvalid = 1; wdata = 32'h22222222; #1;
    chk("abort_wready_low", {63'h0, wready}, 64'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("abort_bvalid_low", {63'h0, bvalid}, 64'h0);
    wvalid = 0; rst_n = 1;
    do_snoop(6'd21, 2'b00, 32'h0BADF00D, 1, 0);
    do_read(6'd7, 32'h11111111, 1, 0);
    do_snoop(6'd7, 2'b01, 32'h11111111, 1, 0);

    repeat (2) @(negedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
